// File: rtl/sca_capture_trigger_pkg.sv
// Shared types and constants for the SCA capture trigger conditioner.
// Optional MaxPulse timeout is enabled by defining SCA_CAPTURE_TIMEOUT_EN.
package sca_capture_trigger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    ACTIVE,
    HOLDOFF
  } sca_trig_state_e;

  localparam int unsigned DEF_CNT_W          = 16;
  localparam int unsigned DEF_DELAY_CYCLES   = 2;
  localparam int unsigned DEF_MIN_PULSE      = 4;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 8;
  localparam int unsigned DEF_MAX_PULSE      = 1024;

  // A down-counter loaded with N-1 reaches zero after exactly N cycles.
  function automatic int unsigned cnt_load_value(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/sca_capture_cnt.sv
// Loadable down-counter with zero flag, shared by the DELAY and HOLDOFF phases.
module sca_capture_cnt #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [CntW-1:0] count_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/sca_capture_trigger.sv
// Conditions the software capture trigger into a delayed, width-limited pulse.
// Define SCA_CAPTURE_TIMEOUT_EN to end pulses after MaxPulse cycles.
module sca_capture_trigger
  import sca_capture_trigger_pkg::*;
#(
  parameter int unsigned CntW          = DEF_CNT_W,
  parameter int unsigned DelayCycles   = DEF_DELAY_CYCLES,
  parameter int unsigned MinPulse      = DEF_MIN_PULSE,
  parameter int unsigned HoldoffCycles = DEF_HOLDOFF_CYCLES,
  parameter int unsigned MaxPulse      = DEF_MAX_PULSE
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            sw_trig_i,
  input  logic            aes_idle_i,
  output logic            trig_o,
  output logic            armed_o,
  output logic [CntW-1:0] busy_cycles_o,
  output logic [CntW-1:0] capture_cnt_o,
  output logic            timeout_o
);

`ifdef SCA_CAPTURE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CntW-1:0] DELAY_LOAD   = CntW'(cnt_load_value(DelayCycles));
  localparam logic [CntW-1:0] HOLDOFF_LOAD = CntW'(cnt_load_value(HoldoffCycles));
  localparam logic [CntW-1:0] MIN_PULSE_C  = CntW'(MinPulse);
  localparam logic [CntW-1:0] MAX_PULSE_C  = CntW'(MaxPulse);

  sca_trig_state_e state_reg, state_next;
  logic            sw_trig_q;
  logic            sw_rise;
  logic            trig_reg;
  logic [CntW-1:0] pulse_cnt_reg;
  logic [CntW-1:0] busy_cycles_reg;
  logic [CntW-1:0] capture_cnt_reg;
  logic            cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_dec;
  logic            cnt_zero;
  logic            exit_normal;
  logic            exit_timeout;
  logic            enter_active;
  logic            leave_active;

  assign sw_rise = sw_trig_i & ~sw_trig_q;

  sca_capture_cnt #(
    .CntW(CntW)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    exit_normal  = aes_idle_i && (pulse_cnt_reg >= MIN_PULSE_C);
    exit_timeout = TIMEOUT_EN && (pulse_cnt_reg >= MAX_PULSE_C);
    case (state_reg)
      IDLE: begin
        if (sw_rise) state_next = ARMED;
      end
      ARMED: begin
        // Dropping the request wins over AES becoming busy in the same cycle.
        if (!sw_trig_i) begin
          state_next = IDLE;
        end else if (!aes_idle_i) begin
          if (DelayCycles == 0) begin
            state_next = ACTIVE;
          end else begin
            state_next   = DELAY;
            cnt_load     = 1'b1;
            cnt_load_val = DELAY_LOAD;
          end
        end
      end
      DELAY: begin
        if (!sw_trig_i) begin
          state_next = IDLE;
        end else if (cnt_zero) begin
          state_next = ACTIVE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACTIVE: begin
        if (exit_normal || exit_timeout) begin
          state_next   = HOLDOFF;
          cnt_load     = 1'b1;
          cnt_load_val = HOLDOFF_LOAD;
        end
      end
      HOLDOFF: begin
        if (cnt_zero) begin
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign enter_active = (state_next == ACTIVE) && (state_reg != ACTIVE);
  assign leave_active = (state_reg == ACTIVE) && (state_next != ACTIVE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      sw_trig_q       <= 1'b0;
      trig_reg        <= 1'b0;
      pulse_cnt_reg   <= '0;
      busy_cycles_reg <= '0;
      capture_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      sw_trig_q <= sw_trig_i;
      // Registered so trig_o mirrors the ACTIVE state without a decode glitch.
      trig_reg  <= (state_next == ACTIVE);
      if (enter_active) begin
        pulse_cnt_reg   <= CntW'(1);
        capture_cnt_reg <= capture_cnt_reg + 1'b1;
      end else if ((state_next == ACTIVE) && (pulse_cnt_reg != '1)) begin
        pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
      end
      if (leave_active) busy_cycles_reg <= pulse_cnt_reg;
    end
  end

`ifdef SCA_CAPTURE_TIMEOUT_EN
  logic timeout_reg;

  // A simultaneous normal exit counts as normal and clears the flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_reg <= 1'b0;
    end else if (leave_active) begin
      timeout_reg <= ~exit_normal;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

  assign trig_o        = trig_reg;
  assign armed_o       = (state_reg == ARMED) || (state_reg == DELAY);
  assign busy_cycles_o = busy_cycles_reg;
  assign capture_cnt_o = capture_cnt_reg;

endmodule

// File: tb/tb_sca_capture_trigger.sv
// Directed and randomized checks of sca_capture_trigger against a pulse-timing model.
// Expected timeout behaviour follows SCA_CAPTURE_TIMEOUT_EN when it is defined.
module tb_sca_capture_trigger;

  localparam int CNT_W = 16;
  localparam int DLY   = 2;
  localparam int MINP  = 4;
  localparam int HOLD  = 8;
  localparam int MAXP  = 16;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             sw_trig_i;
  logic             aes_idle_i;
  logic             trig_o;
  logic             armed_o;
  logic [CNT_W-1:0] busy_cycles_o;
  logic [CNT_W-1:0] capture_cnt_o;
  logic             timeout_o;

  int total = 0;
  int bad   = 0;
  int cap_exp  = 0;
  int busy_exp = 0;
  int tmo_exp  = 0;

  logic sw_pat    [0:255];
  logic idle_pat  [0:255];
  logic trig_obs  [0:255];
  logic armed_obs [0:255];

  sca_capture_trigger #(
    .CntW          (CNT_W),
    .DelayCycles   (DLY),
    .MinPulse      (MINP),
    .HoldoffCycles (HOLD),
    .MaxPulse      (MAXP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .sw_trig_i     (sw_trig_i),
    .aes_idle_i    (aes_idle_i),
    .trig_o        (trig_o),
    .armed_o       (armed_o),
    .busy_cycles_o (busy_cycles_o),
    .capture_cnt_o (capture_cnt_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 256; i++) begin
      sw_pat[i]    = 1'b0;
      idle_pat[i]  = 1'b1;
      trig_obs[i]  = 1'b0;
      armed_obs[i] = 1'b0;
    end
  endtask

  // Pattern index i is sampled at clock edge i; observation i is taken 1 time unit later.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sw_trig_i  = sw_pat[i];
      aes_idle_i = idle_pat[i];
      @(posedge clk);
      #1;
      trig_obs[i]  = trig_o;
      armed_obs[i] = armed_o;
    end
  endtask

  function automatic int trig_count(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (trig_obs[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int armed_count(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (armed_obs[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int trig_first(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (trig_obs[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int trig_rises(input int n);
    int c = 0;
    logic prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (trig_obs[i] === 1'b1 && prev !== 1'b1) c++;
      prev = trig_obs[i];
    end
    return c;
  endfunction

  // Request rises at cycle 0 and is held; AES is busy for blen cycles from cycle bs (bs >= 1).
  task automatic run_txn(input int bs, input int blen, input string tag);
    int n, s, c, lu, len, tmo;
    clear_pat();
    n = bs + blen + MINP + DLY + HOLD + 12;
    for (int i = 0; i < n - 2; i++) sw_pat[i] = 1'b1;
    for (int i = bs; i < bs + blen; i++) idle_pat[i] = 1'b0;
    run_cycles(n);
    // First busy sample in ARMED is at cycle bs; pulse starts DLY+1 cycles later.
    s  = bs + DLY + 1;
    c  = (s + MINP - 1 > bs + blen) ? s + MINP - 1 : bs + blen;
    lu = c - s + 1;
`ifdef SCA_CAPTURE_TIMEOUT_EN
    tmo = (lu > MAXP) ? 1 : 0;
    len = (lu > MAXP) ? MAXP : lu;
`else
    tmo = 0;
    len = lu;
`endif
    cap_exp  = (cap_exp + 1) % (1 << CNT_W);
    busy_exp = len;
    tmo_exp  = tmo;
    $display("txn %s: bs=%0d blen=%0d rise_obs=%0d len=%0d busy=%0d cap=%0d tmo=%0b",
             tag, bs, blen, trig_first(0, n - 1), trig_count(0, n - 1),
             busy_cycles_o, capture_cnt_o, timeout_o);
    check({tag, ".first"}, trig_first(0, n - 1), s - 1);
    check({tag, ".len"},   trig_count(0, n - 1), len);
    check({tag, ".rises"}, trig_rises(n), 1);
    check({tag, ".armed"}, armed_count(0, n - 1), s - 1);
    check({tag, ".busy"},  int'(busy_cycles_o), busy_exp);
    check({tag, ".cap"},   int'(capture_cnt_o), cap_exp);
    check({tag, ".tmo"},   int'(timeout_o), tmo_exp);
  endtask

  initial begin
    rst_i      = 1'b1;
    sw_trig_i  = 1'b0;
    aes_idle_i = 1'b1;
    clear_pat();
    repeat (3) @(posedge clk);
    #1;
    check("rst.trig",  int'(trig_o), 0);
    check("rst.armed", int'(armed_o), 0);
    check("rst.busy",  int'(busy_cycles_o), 0);
    check("rst.cap",   int'(capture_cnt_o), 0);
    check("rst.tmo",   int'(timeout_o), 0);
    rst_i = 1'b0;
    run_cycles(2);

    // Abort: request drops in its first ARMED cycle with AES idle.
    clear_pat();
    sw_pat[0] = 1'b1;
    run_cycles(8);
    $display("txn abort: armed0=%0b armed1=%0b trig=%0d cap=%0d",
             armed_obs[0], armed_obs[1], trig_count(0, 7), capture_cnt_o);
    check("abort.armed0", int'(armed_obs[0]), 1);
    check("abort.armed1", int'(armed_obs[1]), 0);
    check("abort.trig",   trig_count(0, 7), 0);
    check("abort.cap",    int'(capture_cnt_o), 0);

    run_txn(1, 20, "basic");
    run_txn(1, 1, "minpulse");

    // Holdoff: rise at 10 lands in HOLDOFF and is lost; rise at 16 is the first accepted.
    clear_pat();
    for (int i = 0; i <= 5; i++) sw_pat[i] = 1'b1;
    for (int i = 10; i <= 12; i++) sw_pat[i] = 1'b1;
    for (int i = 16; i <= 30; i++) sw_pat[i] = 1'b1;
    idle_pat[1]  = 1'b0;
    idle_pat[17] = 1'b0;
    run_cycles(40);
    cap_exp  = cap_exp + 2;
    busy_exp = MINP;
    tmo_exp  = 0;
    $display("txn holdoff: trig=%0d rises=%0d second=%0d cap=%0d",
             trig_count(0, 39), trig_rises(40), trig_first(8, 39), capture_cnt_o);
    check("hold.first1",  trig_first(0, 39), 3);
    check("hold.lost",    armed_count(9, 15), 0);
    check("hold.rearm",   int'(armed_obs[16]), 1);
    check("hold.second",  trig_first(8, 39), 19);
    check("hold.trig",    trig_count(0, 39), 2 * MINP);
    check("hold.rises",   trig_rises(40), 2);
    check("hold.busy",    int'(busy_cycles_o), busy_exp);
    check("hold.cap",     int'(capture_cnt_o), cap_exp);

    run_txn(1, 100, "long");
    run_txn(2, 6, "after_long");

    for (int k = 0; k < 12; k++) begin
      run_txn(int'($urandom_range(1, 4)), int'($urandom_range(1, 40)), $sformatf("rand%0d", k));
    end

    // Reset in the middle of an ACTIVE pulse.
    clear_pat();
    for (int i = 0; i < 30; i++) sw_pat[i] = 1'b1;
    for (int i = 1; i < 30; i++) idle_pat[i] = 1'b0;
    run_cycles(8);
    check("midrst.pre_trig", int'(trig_o), 1);
    rst_i = 1'b1;
    #1;
    $display("txn midrst: trig=%0b armed=%0b busy=%0d cap=%0d tmo=%0b",
             trig_o, armed_o, busy_cycles_o, capture_cnt_o, timeout_o);
    check("midrst.trig",  int'(trig_o), 0);
    check("midrst.armed", int'(armed_o), 0);
    check("midrst.busy",  int'(busy_cycles_o), 0);
    check("midrst.cap",   int'(capture_cnt_o), 0);
    check("midrst.tmo",   int'(timeout_o), 0);
    sw_trig_i  = 1'b0;
    aes_idle_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i    = 1'b0;
    cap_exp  = 0;
    busy_exp = 0;
    tmo_exp  = 0;
    @(posedge clk);
    #1;
    run_txn(2, 10, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
